// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle shift unit. It shifts one bit per clock and
// implements SLL, SRL and SRA with a start/busy/done handshake. The execute
// stage stalls while busy is high.
//
// Ports:
//   clk, rst_n  rising-edge clock, asynchronous active-low reset
//   start       request, sampled only when not busy (IDLE or DONE)
//   op          00 SLL, 01 SRL, 10 SRA, 11 treated as SLL
//   data_in     operand, captured when start is accepted
//   shamt_in    shift amount; only [SHAMT_W-1:0] is used
//   busy        high while shifting
//   done        one-cycle pulse when result has just been updated
//   result      last completed result, held until the next completion
module iter_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [31:0]      shamt_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]           op_q, op_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     acc_step;

  // Upper shift-amount bits are architecturally ignored.
  logic unused_shamt_hi;
  assign unused_shamt_hi = ^shamt_in[31:SHAMT_W];

  // One-bit shift of the accumulator according to the latched op.
  always_comb begin
    case (op_q)
      2'b01:   acc_step = {1'b0, acc_q[WIDTH-1:1]};
      2'b10:   acc_step = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
      default: acc_step = {acc_q[WIDTH-2:0], 1'b0};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    result_d = result_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_SHIFT: begin
        if (cnt_q != '0) begin
          acc_d  = acc_step;
          cnt_d  = cnt_q - SHAMT_W'(1);
          busy_d = 1'b1;
        end else begin
          // Count exhausted: publish and pulse done for one cycle.
          result_d = acc_q;
          state_d  = S_DONE;
          done_d   = 1'b1;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request, which allows
        // back-to-back operations straight out of DONE.
        if (start) begin
          acc_d   = data_in;
          cnt_d   = shamt_in[SHAMT_W-1:0];
          op_d    = op;
          state_d = S_SHIFT;
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Scoreboard bench for iter_shifter: stimulus pushes expected result and
// completion edge; a monitor pops and compares on every done pulse.
module tb_iter_shifter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] data_in;
  logic [31:0] shamt_in;
  logic        busy;
  logic        done;
  logic [31:0] result;

  iter_shifter #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .data_in(data_in),
    .shamt_in(shamt_in), .busy(busy), .done(done), .result(result)
  );

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   stop_mon = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge with the DUT in IDLE or DONE.
  task automatic issue(input logic [1:0] o, input logic [31:0] d, input logic [31:0] sh,
                       input logic [31:0] exp, input bit push);
    exp_t e;
    start    = 1'b1;
    op       = o;
    data_in  = d;
    shamt_in = sh;
    e.res = exp;
    e.cyc = cyc + 1 + int'(sh[4:0]) + 1;
    if (push) q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    // Operands are captured at the start edge; scramble them to prove it.
    data_in  = ~d;
    op       = o ^ 2'b11;
    shamt_in = $urandom;
  endtask

  // Waits (bounded) for a done pulse and checks the busy cycle count.
  task automatic wait_done(input string name, input int exp_busy);
    int b    = 0;
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (busy) b++;
      if (done) seen = 1;
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    chk({name, "_busy_cycles"}, 32'(b), 32'(exp_busy));
  endtask

  // Monitor: scoreboard compare on done, plus handshake invariants.
  initial begin
    logic [31:0] prev_res = '0;
    logic        prev_rst = 1'b0;
    exp_t        e;
    while (!stop_mon) begin
      @(negedge clk);
      if (rst_n && done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("result", result, e.res);
          chk("done_edge", 32'(cyc), 32'(e.cyc));
        end
      end
      if (rst_n) chk("busy_and_done", 32'(busy & done), 32'd0);
      if (rst_n && prev_rst && !done) chk("result_hold", result, prev_res);
      prev_res = result;
      prev_rst = rst_n;
    end
  end

  initial begin
    rst_n    = 1'b1;
    start    = 1'b0;
    op       = 2'b00;
    data_in  = '0;
    shamt_in = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // SRA of sign bit by 4.
    issue(2'b10, 32'h8000_0000, 32'd4, 32'hF800_0000, 1);
    wait_done("sra4", 5);
    // SLL with ignored upper shamt bits (n=5).
    @(negedge clk);
    issue(2'b00, 32'h0000_0001, 32'h0000_0025, 32'h0000_0020, 1);
    wait_done("sll5", 6);
    // SRL by 31: 32 busy cycles.
    @(negedge clk);
    issue(2'b01, 32'h8000_0000, 32'd31, 32'h0000_0001, 1);
    wait_done("srl31", 32);
    // SRA negative by 31 and positive by 8; reserved op as SLL.
    @(negedge clk);
    issue(2'b10, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1);
    wait_done("sra31", 32);
    @(negedge clk);
    issue(2'b10, 32'h7000_0000, 32'd8, 32'h0070_0000, 1);
    wait_done("sra8pos", 9);
    @(negedge clk);
    issue(2'b11, 32'h0000_00F0, 32'd4, 32'h0000_0F00, 1);
    wait_done("rsvd", 5);
    // Zero shift, then start held in DONE for a back-to-back SLL by 1.
    @(negedge clk);
    issue(2'b10, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 1);
    wait_done("sh0", 1);
    issue(2'b00, 32'hDEAD_BEEF, 32'd1, 32'hBD5B_7DDE, 1);
    wait_done("b2b", 2);

    // Reset mid-operation: second start ignored, no done, outputs cleared.
    @(negedge clk);
    issue(2'b00, 32'h0000_0001, 32'd10, 32'h0, 0);
    repeat (3) @(negedge clk);
    start   = 1'b1;
    data_in = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_ignored_start", 32'(busy), 32'd1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_result", result, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_result", result, 32'd0);

    // Recovery after reset.
    issue(2'b01, 32'hF000_000F, 32'd2, 32'h3C00_0003, 1);
    wait_done("recover", 3);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    stop_mon = 1;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
